exe_stage: RTL and testbench
============================

# exe_stage

Execute stage of the 5-stage ARM pipeline. Consumes the ID/EX pipeline register outputs and computes the second ALU operand (Val2), the ALU result with NZCV flags, and the branch target. It owns the architectural status register that the decode stage reads for condition checks, and registers its results into the EX/MEM boundary.

## Interface
Parameters: none. Fixed 32-bit datapath.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-low
- freeze  in  1  memory-stage stall; holds EX/MEM outputs and status register
- wb_en_in, mem_read_in, mem_write_in  in  1 each  control from ID/EX
- B_in  in  1  branch instruction
- S_in  in  1  update status register
- imm_in  in  1  shift_operand is a rotated immediate
- exe_cmd_in  in  4  ALU command
- PC_in  in  32  PC+4 of the instruction
- val_Rn_in, val_Rm_in  in  32  register operands
- shift_operand_in  in  12  Val2 encoding
- signed_imm_24_in  in  24  branch offset
- dest_in  in  4  destination register
- SR_in  in  4  {N,Z,C,V} forwarded through ID/EX; carry-in source
- branch_taken  out  1  combinational, = B_in
- branch_addr  out  32  combinational
- SR  out  4  status register {N,Z,C,V} to decode stage
- wb_en, mem_read, mem_write  out  1 each  registered
- alu_res  out  32  registered
- val_Rm  out  32  registered store data
- dest  out  4  registered

## Operation
- Val2:
  - imm_in=1: {24'b0, shift_operand[7:0]} rotated right by 2*shift_operand[11:8].
  - imm_in=0 and (mem_read_in or mem_write_in): zero-extended shift_operand[11:0].
  - otherwise: val_Rm_in shifted by shift_operand[11:7] using type shift_operand[6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR. A shift of 0 passes the value through.
- ALU (cin = SR_in[1]):
  - 0001 MOV: Val2
  - 1001 MVN: ~Val2
  - 0010 ADD/LDR/STR: Rn+Val2
  - 0011 ADC: Rn+Val2+cin
  - 0100 SUB/CMP: Rn−Val2
  - 0101 SBC: Rn−Val2−!cin
  - 0110 AND/TST: Rn&Val2
  - 0111 ORR: Rn|Val2
  - 1000 EOR: Rn^Val2
  - Any other code gives result 0.
- Flags:
  - N = res[31]; Z = (res==0).
  - Add ops: C = carry-out of the 33-bit sum; V = signed overflow.
  - Sub ops: C = NOT borrow; V = signed overflow.
  - Logic/move ops: C and V keep their current SR value.
- Status register: SR <= flags when S_in && !freeze. Otherwise it holds.
- branch_addr = PC_in + (sign_extend(signed_imm_24_in) << 2), mod 2^32.
- EX/MEM register: when !freeze, it captures wb_en_in, mem_read_in, mem_write_in, ALU result, val_Rm_in and dest_in. When freeze=1, all of these hold.

## Timing
- Reset (rst=0 at an edge): SR, wb_en, mem_read, mem_write, alu_res, val_Rm and dest all become 0. Reset has priority over freeze.
- branch_taken and branch_addr have zero latency, in the same cycle as the ID/EX outputs. Instruction fetch uses them to flush IF/ID and ID/EX on the next edge.
- ALU result appears at alu_res 1 cycle after the instruction is on the ID/EX outputs.
- SR reflects a flag-setting instruction 1 cycle later. A dependent conditional instruction in decode during that cycle sees the old SR; the hazard unit is responsible for that case.
- A flushed (bubbled) ID/EX presents all zeros. The result is exe_cmd 0000 with result 0, no SR update and no writeback.
- freeze and S_in asserted together: no SR update. The instruction is re-presented after the freeze clears.
- Reset mid-freeze clears everything at that edge.

## Structure
- Shared package: exe_cmd encodings, shift-type encodings, SR bit indices (N=3, Z=2, C=1, V=0).
- Sub-modules:
  - `val2_gen`: combinational shifter/rotator.
  - The ALU stays inline.
  - The status register and EX/MEM register are local always blocks.

## Test plan
- ADD with Rn=0x7FFFFFFF and imm Val2=1 (shift_operand 0x001), S=1 → alu_res=0x80000000; next cycle SR=1001 (N=1, Z=0, C=0, V=1).
- CMP (0100) with Rn=5, Rm=5, S=1 → SR=0110 (Z=1, C=1). With S=0 and the same operands, SR is unchanged.
- Immediate rotate, shift_operand=0x4FF → Val2=0xFF000000. MOV gives alu_res=0xFF000000. ASR of Rm=0x80000000 by 4 → 0xF8000000.
- ADC with Rn=1, Val2=1, SR_in C=1 → alu_res=3. SBC with Rn=5, Val2=2, C=0 → alu_res=2.
- Branch: B_in=1, PC_in=0x100, imm24=0xFFFFFE → branch_taken=1 and branch_addr=0xF8 in the same cycle.
- freeze=1 for 2 cycles while ADD S=1 is presented → alu_res and SR hold. rst=0 during freeze → all outputs 0 at that edge.

Source files
------------

// File: rtl/exe_pkg.sv
// Shared definitions for the execute stage.
//   exe_cmd_e : ALU command encodings carried on exe_cmd
//   shift_e   : register-shift types carried in shift_operand[6:5]
//   SR_*      : bit positions of the {N,Z,C,V} status register
//   ror32     : 32-bit rotate-right helper used by the Val2 generator
package exe_pkg;

  typedef enum logic [3:0] {
    CMD_NOP = 4'b0000,
    CMD_MOV = 4'b0001,
    CMD_ADD = 4'b0010,
    CMD_ADC = 4'b0011,
    CMD_SUB = 4'b0100,
    CMD_SBC = 4'b0101,
    CMD_AND = 4'b0110,
    CMD_ORR = 4'b0111,
    CMD_EOR = 4'b1000,
    CMD_MVN = 4'b1001
  } exe_cmd_e;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_e;

  localparam int SR_N = 3;
  localparam int SR_Z = 2;
  localparam int SR_C = 1;
  localparam int SR_V = 0;

  // Rotate right by shifting a doubled copy; a rotate of 0 is the identity.
  function automatic logic [31:0] ror32(input logic [31:0] value,
                                        input logic [4:0]  amount);
    logic [63:0] doubled;
    doubled = {value, value} >> amount;
    return doubled[31:0];
  endfunction

endpackage

// File: rtl/exe_stage_val2_gen.sv
// Second-operand (Val2) generator for the execute stage. Purely combinational.
//   imm           : shift_operand holds an 8-bit immediate plus 4-bit rotate
//   mem_access    : load/store address offset, zero-extended 12-bit field
//   shift_operand : 12-bit operand encoding
//   val_Rm        : register operand to be shifted
//   val2          : resulting second ALU operand
module val2_gen
  import exe_pkg::*;
(
  input  logic        imm,
  input  logic        mem_access,
  input  logic [11:0] shift_operand,
  input  logic [31:0] val_Rm,
  output logic [31:0] val2
);

  logic [4:0] shamt;
  logic [4:0] rot_amt;

  assign shamt   = shift_operand[11:7];
  // Immediate rotate field counts in steps of two bit positions.
  assign rot_amt = {shift_operand[11:8], 1'b0};

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    val2 = val_Rm;
    if (imm) begin
      val2 = ror32({24'b0, shift_operand[7:0]}, rot_amt);
    end else if (mem_access) begin
      val2 = {20'b0, shift_operand};
    end else begin
      case (shift_e'(shift_operand[6:5]))
        SH_LSL:  val2 = val_Rm << shamt;
        SH_LSR:  val2 = val_Rm >> shamt;
        SH_ASR:  val2 = $unsigned($signed(val_Rm) >>> shamt);
        SH_ROR:  val2 = ror32(val_Rm, shamt);
        default: val2 = val_Rm;
      endcase
    end
  end

endmodule

// File: rtl/exe_stage.sv
// Execute stage of the 5-stage ARM pipeline.
//   Inputs : ID/EX control (wb_en/mem_read/mem_write/B/S/imm/exe_cmd), PC+4,
//            register operands, shift_operand, 24-bit branch offset, dest,
//            forwarded SR_in (carry-in source), freeze (memory stall).
//   Outputs: branch_taken/branch_addr (combinational, to fetch),
//            SR (architectural status register, to decode),
//            EX/MEM register: wb_en, mem_read, mem_write, alu_res, val_Rm, dest.
module exe_stage
  import exe_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        wb_en_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        B_in,
  input  logic        S_in,
  input  logic        imm_in,
  input  logic [3:0]  exe_cmd_in,
  input  logic [31:0] PC_in,
  input  logic [31:0] val_Rn_in,
  input  logic [31:0] val_Rm_in,
  input  logic [11:0] shift_operand_in,
  input  logic [23:0] signed_imm_24_in,
  input  logic [3:0]  dest_in,
  input  logic [3:0]  SR_in,
  output logic        branch_taken,
  output logic [31:0] branch_addr,
  output logic [3:0]  SR,
  output logic        wb_en,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] alu_res,
  output logic [31:0] val_Rm,
  output logic [3:0]  dest
);

  logic [31:0] val2;
  logic        cin;
  logic [32:0] sum;
  logic [31:0] res;
  logic        add_op;
  logic        sub_op;
  logic        c_flag;
  logic        v_flag;
  logic [3:0]  flags;
  logic        unused_sr_bits;

  // Only the carry of the forwarded status feeds the ALU.
  assign cin            = SR_in[SR_C];
  assign unused_sr_bits = ^{SR_in[SR_N], SR_in[SR_Z], SR_in[SR_V]};

  val2_gen u_val2_gen (
    .imm           (imm_in),
    .mem_access    (mem_read_in | mem_write_in),
    .shift_operand (shift_operand_in),
    .val_Rm        (val_Rm_in),
    .val2          (val2)
  );

  // Subtraction is done as Rn + ~Val2 + carry, so the carry-out is NOT borrow.
  always_comb begin
    sum    = '0;
    res    = '0;
    add_op = 1'b0;
    sub_op = 1'b0;
    case (exe_cmd_e'(exe_cmd_in))
      CMD_MOV: res = val2;
      CMD_MVN: res = ~val2;
      CMD_ADD: begin
        sum    = {1'b0, val_Rn_in} + {1'b0, val2};
        add_op = 1'b1;
      end
      CMD_ADC: begin
        sum    = {1'b0, val_Rn_in} + {1'b0, val2} + {32'b0, cin};
        add_op = 1'b1;
      end
      CMD_SUB: begin
        sum    = {1'b0, val_Rn_in} + {1'b0, ~val2} + 33'd1;
        sub_op = 1'b1;
      end
      CMD_SBC: begin
        sum    = {1'b0, val_Rn_in} + {1'b0, ~val2} + {32'b0, cin};
        sub_op = 1'b1;
      end
      CMD_AND: res = val_Rn_in & val2;
      CMD_ORR: res = val_Rn_in | val2;
      CMD_EOR: res = val_Rn_in ^ val2;
      default: res = '0;
    endcase
    if (add_op || sub_op) begin
      res = sum[31:0];
    end
  end

  // Logic/move ops leave C and V at their architectural values.
  always_comb begin
    c_flag = SR[SR_C];
    v_flag = SR[SR_V];
    if (add_op) begin
      c_flag = sum[32];
      v_flag = (val_Rn_in[31] == val2[31]) && (res[31] != val_Rn_in[31]);
    end else if (sub_op) begin
      c_flag = sum[32];
      v_flag = (val_Rn_in[31] != val2[31]) && (res[31] != val_Rn_in[31]);
    end
  end

  always_comb begin
    flags       = '0;
    flags[SR_N] = res[31];
    flags[SR_Z] = (res == 32'd0);
    flags[SR_C] = c_flag;
    flags[SR_V] = v_flag;
  end

  assign branch_taken = B_in;
  assign branch_addr  = PC_in + {{6{signed_imm_24_in[23]}}, signed_imm_24_in, 2'b00};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering. Reset is sampled
  // synchronously and wins over freeze.
  always_ff @(posedge clk) begin
    if (!rst) begin
      SR <= '0;
    end else if (S_in && !freeze) begin
      SR <= flags;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_en     <= 1'b0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      alu_res   <= '0;
      val_Rm    <= '0;
      dest      <= '0;
    end else if (!freeze) begin
      wb_en     <= wb_en_in;
      mem_read  <= mem_read_in;
      mem_write <= mem_write_in;
      alu_res   <= res;
      val_Rm    <= val_Rm_in;
      dest      <= dest_in;
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// Directed self-checking bench for exe_stage.
module tb_exe_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        wb_en_in, mem_read_in, mem_write_in;
  logic        B_in, S_in, imm_in;
  logic [3:0]  exe_cmd_in;
  logic [31:0] PC_in, val_Rn_in, val_Rm_in;
  logic [11:0] shift_operand_in;
  logic [23:0] signed_imm_24_in;
  logic [3:0]  dest_in, SR_in;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic [3:0]  SR;
  logic        wb_en, mem_read, mem_write;
  logic [31:0] alu_res, val_Rm;
  logic [3:0]  dest;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  exe_stage dut (
    .clk              (clk),
    .rst              (rst),
    .freeze           (freeze),
    .wb_en_in         (wb_en_in),
    .mem_read_in      (mem_read_in),
    .mem_write_in     (mem_write_in),
    .B_in             (B_in),
    .S_in             (S_in),
    .imm_in           (imm_in),
    .exe_cmd_in       (exe_cmd_in),
    .PC_in            (PC_in),
    .val_Rn_in        (val_Rn_in),
    .val_Rm_in        (val_Rm_in),
    .shift_operand_in (shift_operand_in),
    .signed_imm_24_in (signed_imm_24_in),
    .dest_in          (dest_in),
    .SR_in            (SR_in),
    .branch_taken     (branch_taken),
    .branch_addr      (branch_addr),
    .SR               (SR),
    .wb_en            (wb_en),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .alu_res          (alu_res),
    .val_Rm           (val_Rm),
    .dest             (dest)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One clock: returns 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bubble();
    wb_en_in = 0; mem_read_in = 0; mem_write_in = 0;
    B_in = 0; S_in = 0; imm_in = 0; exe_cmd_in = 4'b0000;
    PC_in = 0; val_Rn_in = 0; val_Rm_in = 0; shift_operand_in = 0;
    signed_imm_24_in = 0; dest_in = 0; SR_in = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sr"},        32'(SR), 32'h0);
    check({tag, "_wb_en"},     32'(wb_en), 32'h0);
    check({tag, "_mem_read"},  32'(mem_read), 32'h0);
    check({tag, "_mem_write"}, 32'(mem_write), 32'h0);
    check({tag, "_alu_res"},   alu_res, 32'h0);
    check({tag, "_val_rm"},    val_Rm, 32'h0);
    check({tag, "_dest"},      32'(dest), 32'h0);
  endtask

  initial begin
    // Reset with a live flag-setting instruction presented: reset must win.
    bubble();
    rst = 0; freeze = 0;
    exe_cmd_in = 4'b0010; val_Rn_in = 32'h7FFF_FFFF; imm_in = 1;
    shift_operand_in = 12'h001; S_in = 1; wb_en_in = 1; dest_in = 4'd3;
    val_Rm_in = 32'h1234; mem_write_in = 1;
    step(); step();
    check_all_zero("reset");

    // ADD overflow, S=1.
    rst = 1; mem_write_in = 0;
    step();
    check("add_ovf_res", alu_res, 32'h8000_0000);
    check("add_ovf_sr", 32'(SR), 32'b1001);
    check("add_ovf_dest", 32'(dest), 32'd3);
    check("add_ovf_wb", 32'(wb_en), 32'd1);
    check("add_ovf_val_rm", val_Rm, 32'h1234);

    // CMP 5,5 with S=1 -> Z=1, C=1.
    bubble();
    exe_cmd_in = 4'b0100; val_Rn_in = 5; val_Rm_in = 5; S_in = 1;
    step();
    check("cmp_eq_res", alu_res, 32'h0);
    check("cmp_eq_sr", 32'(SR), 32'b0110);
    check("cmp_eq_wb", 32'(wb_en), 32'd0);

    // Same CMP with S=0 keeps SR; then different operands with S=0 too.
    S_in = 0;
    step();
    check("cmp_nos_sr", 32'(SR), 32'b0110);
    val_Rn_in = 3;
    step();
    check("sub_nos_res", alu_res, 32'hFFFF_FFFE);
    check("sub_nos_sr", 32'(SR), 32'b0110);

    // Immediate rotate: 0xFF ror 8.
    bubble();
    exe_cmd_in = 4'b0001; imm_in = 1; shift_operand_in = 12'h4FF;
    step();
    check("mov_imm_rot", alu_res, 32'hFF00_0000);

    // Register shifts through MOV.
    bubble();
    exe_cmd_in = 4'b0001; val_Rm_in = 32'h8000_0000; shift_operand_in = 12'h240; // ASR #4
    step();
    check("mov_asr4", alu_res, 32'hF800_0000);
    val_Rm_in = 32'h0000_00F1; shift_operand_in = 12'h260;                    // ROR #4
    step();
    check("mov_ror4", alu_res, 32'h1000_000F);
    val_Rm_in = 32'h0000_0001; shift_operand_in = 12'hF80;                    // LSL #31
    step();
    check("mov_lsl31", alu_res, 32'h8000_0000);
    val_Rm_in = 32'h8000_0000; shift_operand_in = 12'hFA0;                    // LSR #31
    step();
    check("mov_lsr31", alu_res, 32'h0000_0001);
    val_Rm_in = 32'hDEAD_BEEF; shift_operand_in = 12'h060;                    // ROR #0
    step();
    check("mov_shift0", alu_res, 32'hDEAD_BEEF);

    // LDR address: 12-bit zero-extended offset, not a shift.
    bubble();
    exe_cmd_in = 4'b0010; mem_read_in = 1; wb_en_in = 1; val_Rn_in = 32'h1000;
    shift_operand_in = 12'hFFF; dest_in = 4'd7;
    step();
    check("ldr_addr", alu_res, 32'h0000_1FFF);
    check("ldr_mem_read", 32'(mem_read), 32'd1);
    check("ldr_dest", 32'(dest), 32'd7);

    // STR: store data passes through.
    bubble();
    exe_cmd_in = 4'b0010; mem_write_in = 1; val_Rn_in = 32'h20;
    val_Rm_in = 32'hCAFE_BABE; shift_operand_in = 12'h004;
    step();
    check("str_addr", alu_res, 32'h24);
    check("str_mem_write", 32'(mem_write), 32'd1);
    check("str_mem_read", 32'(mem_read), 32'd0);
    check("str_val_rm", val_Rm, 32'hCAFE_BABE);

    // ADC / SBC using forwarded carry.
    bubble();
    exe_cmd_in = 4'b0011; val_Rn_in = 1; imm_in = 1; shift_operand_in = 12'h001;
    SR_in = 4'b0010;
    step();
    check("adc_c1", alu_res, 32'd3);
    exe_cmd_in = 4'b0101; val_Rn_in = 5; shift_operand_in = 12'h002; SR_in = 4'b0000;
    step();
    check("sbc_c0", alu_res, 32'd2);

    // Logic ops and an unused command.
    bubble();
    imm_in = 1;
    exe_cmd_in = 4'b0110; val_Rn_in = 32'h0000_F0F0; shift_operand_in = 12'h0FF;
    step();
    check("and", alu_res, 32'h0000_00F0);
    exe_cmd_in = 4'b1000; val_Rn_in = 32'hFF00_FF00;
    step();
    check("eor", alu_res, 32'hFF00_FFFF);
    exe_cmd_in = 4'b1001; shift_operand_in = 12'h000;
    step();
    check("mvn", alu_res, 32'hFFFF_FFFF);
    exe_cmd_in = 4'b1111; val_Rn_in = 5; shift_operand_in = 12'h001;
    step();
    check("bad_cmd", alu_res, 32'h0);

    // ORR with S=1: N from result, C/V kept from SR (0110).
    exe_cmd_in = 4'b0111; val_Rn_in = 32'h8000_0000; shift_operand_in = 12'h0F0;
    S_in = 1; SR_in = 4'b0110;
    step();
    check("orr_s_res", alu_res, 32'h8000_00F0);
    check("orr_s_sr", 32'(SR), 32'b1010);

    // SUB with borrow, S=1.
    bubble();
    exe_cmd_in = 4'b0100; val_Rn_in = 3; imm_in = 1; shift_operand_in = 12'h005; S_in = 1;
    step();
    check("sub_borrow_res", alu_res, 32'hFFFF_FFFE);
    check("sub_borrow_sr", 32'(SR), 32'b1000);

    // Branch target is combinational.
    bubble();
    B_in = 1; PC_in = 32'h100; signed_imm_24_in = 24'hFF_FFFE;
    #1;
    check("br_taken", 32'(branch_taken), 32'd1);
    check("br_back", branch_addr, 32'h0000_00F8);
    PC_in = 32'h200; signed_imm_24_in = 24'h00_0010;
    #1;
    check("br_fwd", branch_addr, 32'h0000_0240);

    // Bubble: result 0, no writeback, SR unchanged.
    bubble();
    #1;
    check("br_not_taken", 32'(branch_taken), 32'd0);
    step();
    check("bubble_res", alu_res, 32'h0);
    check("bubble_wb", 32'(wb_en), 32'd0);
    check("bubble_sr", 32'(SR), 32'b1000);

    // Freeze two cycles with ADD S=1 presented: everything holds.
    exe_cmd_in = 4'b0010; val_Rn_in = 32'h10; imm_in = 1; shift_operand_in = 12'h001;
    S_in = 1; wb_en_in = 1; dest_in = 4'd9; freeze = 1;
    step();
    check("frz1_res", alu_res, 32'h0);
    check("frz1_sr", 32'(SR), 32'b1000);
    check("frz1_dest", 32'(dest), 32'd0);
    step();
    check("frz2_res", alu_res, 32'h0);
    check("frz2_sr", 32'(SR), 32'b1000);
    check("frz2_wb", 32'(wb_en), 32'd0);
    freeze = 0;
    step();
    check("unfrz_res", alu_res, 32'h11);
    check("unfrz_sr", 32'(SR), 32'b0000);
    check("unfrz_dest", 32'(dest), 32'd9);
    check("unfrz_wb", 32'(wb_en), 32'd1);

    // Flag-setting result to make SR nonzero, then reset during freeze.
    val_Rn_in = 32'hFFFF_FFFF; val_Rm_in = 32'h55; mem_read_in = 1; imm_in = 1;
    step();
    check("pre_rst_sr", 32'(SR), 32'b0110);
    freeze = 1; rst = 0;
    step();
    check_all_zero("rst_frz");
    rst = 1; freeze = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
